lsu_rmw: RTL and testbench
==========================

Name: lsu_rmw

Overview:
Load/store unit that sits directly upstream of the word-addressed data memory, between the CPU execute stage and the memory.
- Accepts byte, halfword and word loads and stores over a valid/ready request port.
- Drives the memory's whole-word read/write port.
- Sub-word stores are done as read-modify-write, because the memory only supports whole-word writes.
- Loads return sign- or zero-extended results with a one-cycle response pulse.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the attached memory; byte addresses at or above MEM_WORDS*4 are out of range.
- ADDR_W, 32, request and memory address width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores, errors, and whenever resp_valid=0.
- resp_err  out  1  misaligned, illegal size, or out of range; qualified by resp_valid.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable, sampled by the memory on posedge clk.
- mem_addr  out  ADDR_W  word-aligned byte address, {addr[ADDR_W-1:2],2'b00}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data, valid in the same cycle mem_read=1.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: state=IDLE; resp_valid=0, resp_err=0, resp_rdata=0; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. req_ready=0 while rst=1.
- Outputs outside their active state: mem_read/mem_write/mem_addr/mem_wdata are 0 except in RD/WR; mem_write is additionally gated by !rst.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid & req_ready) in cycle C0 latches we, size, unsigned, addr and wdata.
- Error check at C0: half with addr[0]=1, word with addr[1:0]!=0, size=11, or addr>=MEM_WORDS*4.
  - Go to RESP with err=1, rdata=0.
  - No memory access is issued.
- Next state after C0 without error:
  - load: RD.
  - word store: WR.
  - sub-word store: RD.
- RD:
  - mem_read=1, mem_addr=latched word address.
  - mem_rdata is captured into a word register at the end of the cycle.
  - Load: go to RESP with extracted lane. Byte lane = addr[1:0]; half lane = addr[1].
  - Load extension: sign-extend, or zero-extend if unsigned.
  - Sub-word store: go to WR.
- WR:
  - mem_write=1 for exactly one cycle.
  - Word store: mem_wdata=wdata.
  - Sub-word store: mem_wdata = captured word with the selected lane replaced by wdata[7:0] or wdata[15:0]; other bytes unchanged.
  - Next state: RESP.
- RESP: resp_valid=1 for one cycle with registered rdata/err, then IDLE. There is no backpressure; the consumer must take the response.
- Latency, with resp_valid cycle counted from accept cycle C0:
  - error: C1.
  - load: C2.
  - word store: C2.
  - sub-word store: C3.
- Back-to-back: the next request can be accepted in the cycle after RESP, since req_ready is low during RD/WR/RESP.
- Invariants:
  - mem_read and mem_write are never high together.
  - The memory is never written on a load or on an error.
- Reset mid-operation: the in-flight op is abandoned.
  - No mem_write is issued in any cycle with rst=1.
  - No resp_valid for the abandoned op.
  - Memory is unchanged unless the WR edge already completed.

Decomposition:
- Package lsu_pkg holds:
  - size constants SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
  - state enum lsu_state_t {IDLE,RD,WR,RESP};
  - WORD_BYTES=4.
- One combinational sub-module lsu_align:
  - load path: extract + sign/zero extend (word, addr[1:0], size, unsigned -> 32b);
  - store path: lane merge (old word, wdata, addr[1:0], size -> 32b).
- The FSM and registers stay in lsu_rmw.

Test Plan:
1. Word 3 = 0x0000000A; LW addr 0x0C accepted in C0 -> mem_read=1 only in C1 with mem_addr=0x0C; resp_valid in C2 with rdata=0x0000000A, err=0.
2. Word 1 = 0x8070F0AB:
   - LB 0x5 -> 0xFFFFFFF0.
   - LBU 0x5 -> 0x000000F0.
   - LH 0x6 -> 0xFFFF8070.
   - LHU 0x6 -> 0x00008070.
3. Word 2 = 0x11223344; SB addr 0x9, wdata 0x000000EE:
   - mem_read in C1.
   - mem_write in C2 with mem_wdata=0x1122EE44.
   - resp in C3 with rdata=0.
   - A following LW 0x8 returns 0x1122EE44.
4. SW addr 0x10, wdata 0xDEADBEEF -> no mem_read; mem_write in C1 with mem_wdata=0xDEADBEEF; resp in C2. SH 0x12 0xBEEF then yields word 0xBEEFBEEF.
5. Each of LH 0x3, LW 0x6, size=11, LW 0x400 -> resp_valid in C1 with err=1, rdata=0; mem_read and mem_write stay 0 throughout.
6. Assert rst in C2 (WR) of an SB:
   - mem_write stays 0.
   - No resp_valid.
   - Memory word unchanged.
   - req_ready=1 in the first cycle after rst drops.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;

endpackage

// File: rtl/lsu_rmw_if.sv
// CPU-side request/response port of the load/store unit.
interface lsu_rmw_if #(parameter int ADDR_W = 32);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane datapath: load extraction with sign/zero extension, and
// sub-word merge of store data into an existing memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_data = word;
    case (size)
      SZ_B:    load_data = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = word;
    endcase
  end

  // Each byte lane either takes new store data or keeps the old word's byte.
  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] src;

      assign hit = (size == SZ_B) ? (lane == LANE) :
                   (size == SZ_H) ? (lane[1] == LANE[1]) : 1'b1;
      assign src = (size == SZ_B) ? wdata[7:0] :
                   (size == SZ_H) ? (LANE[0] ? wdata[15:8] : wdata[7:0]) :
                   wdata[8*gi +: 8];
      assign store_data[8*gi +: 8] = hit ? src : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a whole-word memory; sub-word stores are
// performed as a read cycle followed by a merged full-word write.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  lsu_rmw_if.slave          bus,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_WORDS * WORD_BYTES);

  lsu_state_t        state_reg;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              mem_read_reg;
  logic              mem_write_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic              resp_valid_reg;
  logic              resp_err_reg;
  logic [31:0]       resp_rdata_reg;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       store_data;

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      SZ_B:    req_err = 1'b0;
      SZ_H:    req_err = bus.req_addr[0];
      SZ_W:    req_err = |bus.req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({1'b0, bus.req_addr} >= ADDR_LIMIT)
      req_err = 1'b1;
  end

  // Datapath works straight off mem_rdata during RD so the merged word and
  // the load result are both registered at the end of that cycle.
  lsu_align u_align (
    .word        (mem_rdata),
    .wdata       (wdata_reg),
    .lane        (addr_reg[1:0]),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      we_reg         <= 1'b0;
      size_reg       <= SZ_B;
      unsigned_reg   <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
    end else begin
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            we_reg       <= bus.req_we;
            size_reg     <= bus.req_size;
            unsigned_reg <= bus.req_unsigned;
            addr_reg     <= bus.req_addr;
            wdata_reg    <= bus.req_wdata;
            if (req_err) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
            end else if (bus.req_we && bus.req_size == SZ_W) begin
              state_reg     <= WR;
              mem_write_reg <= 1'b1;
              mem_addr_reg  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata_reg <= bus.req_wdata;
            end else begin
              state_reg    <= RD;
              mem_read_reg <= 1'b1;
              mem_addr_reg <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        RD: begin
          if (we_reg) begin
            state_reg     <= WR;
            mem_write_reg <= 1'b1;
            mem_addr_reg  <= mem_addr_reg;
            mem_wdata_reg <= store_data;
          end else begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= load_data;
          end
        end
        WR: begin
          state_reg      <= RESP;
          resp_valid_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_reg == IDLE) && !rst;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign mem_read       = mem_read_reg;
  assign mem_write      = mem_write_reg && !rst;
  assign mem_addr       = mem_addr_reg;
  assign mem_wdata      = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw with a behavioural 256-word memory.
module tb_lsu_rmw;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem [256];

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  lsu_rmw_if #(.ADDR_W(32)) bus ();

  lsu_rmw #(.MEM_WORDS(256), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  assign mem_rdata = mem[mem_addr[9:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Drive one request; expected response goes into the scoreboard and is
  // popped when resp_valid appears. Cycle numbers count from accept cycle C0.
  task automatic run_op(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input int exp_rd, input int exp_wr, input logic [31:0] exp_wdata);
    int          rd_cyc = -1;
    int          wr_cyc = -1;
    int          got_lat = -1;
    logic [31:0] rd_addr = '0;
    logic [31:0] wr_data = '0;
    exp_t        e;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    sb.push_back('{exp_rdata, exp_err, exp_lat});
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (mem_read && rd_cyc < 0) begin rd_cyc = k; rd_addr = mem_addr; end
      if (mem_write && wr_cyc < 0) begin wr_cyc = k; wr_data = mem_wdata; end
      chk({tag, "_excl"}, 32'(mem_read & mem_write), 32'd0);
      if (bus.resp_valid) begin
        got_lat = k;
        if (sb.size() == 0) begin
          chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({tag, "_rdata"}, bus.resp_rdata, e.rdata);
          chk({tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
          chk({tag, "_lat"}, 32'(k), 32'(e.lat));
        end
        break;
      end else begin
        chk({tag, "_rdata_idle"}, bus.resp_rdata, 32'd0);
      end
    end
    if (got_lat < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_rd_cyc"}, 32'(rd_cyc), 32'(exp_rd));
    chk({tag, "_wr_cyc"}, 32'(wr_cyc), 32'(exp_wr));
    if (exp_rd > 0) chk({tag, "_rd_addr"}, rd_addr, {addr[31:2], 2'b00});
    if (exp_wr > 0) chk({tag, "_wdata"}, wr_data, exp_wdata);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_b2b_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    mem[1]   = 32'h8070F0AB;
    mem[2]   = 32'h11223344;
    mem[3]   = 32'h0000000A;
    mem[8]   = 32'hCAFEF00D;
    mem[255] = 32'h7F000000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    //      tag     we    size   uns   addr          wdata          rdata          err  lat rd  wr  wdata
    run_op("lw_c",  1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0,         32'h0000000A, 1'b0, 2, 1, -1, 32'h0);
    run_op("lb5",   1'b0, 2'b00, 1'b0, 32'h00000005, 32'h0,         32'hFFFFFFF0, 1'b0, 2, 1, -1, 32'h0);
    run_op("lbu5",  1'b0, 2'b00, 1'b1, 32'h00000005, 32'h0,         32'h000000F0, 1'b0, 2, 1, -1, 32'h0);
    run_op("lh6",   1'b0, 2'b01, 1'b0, 32'h00000006, 32'h0,         32'hFFFF8070, 1'b0, 2, 1, -1, 32'h0);
    run_op("lhu6",  1'b0, 2'b01, 1'b1, 32'h00000006, 32'h0,         32'h00008070, 1'b0, 2, 1, -1, 32'h0);
    run_op("lb4",   1'b0, 2'b00, 1'b0, 32'h00000004, 32'h0,         32'hFFFFFFAB, 1'b0, 2, 1, -1, 32'h0);
    run_op("lh4",   1'b0, 2'b01, 1'b0, 32'h00000004, 32'h0,         32'hFFFFF0AB, 1'b0, 2, 1, -1, 32'h0);
    run_op("lbu7",  1'b0, 2'b00, 1'b1, 32'h00000007, 32'h0,         32'h00000080, 1'b0, 2, 1, -1, 32'h0);
    run_op("lb3ff", 1'b0, 2'b00, 1'b0, 32'h000003FF, 32'h0,         32'h0000007F, 1'b0, 2, 1, -1, 32'h0);
    run_op("sb9",   1'b1, 2'b00, 1'b0, 32'h00000009, 32'h000000EE,  32'h0,        1'b0, 3, 1, 2, 32'h1122EE44);
    run_op("lw8",   1'b0, 2'b10, 1'b0, 32'h00000008, 32'h0,         32'h1122EE44, 1'b0, 2, 1, -1, 32'h0);
    run_op("sw10",  1'b1, 2'b10, 1'b0, 32'h00000010, 32'hDEADBEEF,  32'h0,        1'b0, 2, -1, 1, 32'hDEADBEEF);
    run_op("sh12",  1'b1, 2'b01, 1'b0, 32'h00000012, 32'h1234BEEF,  32'h0,        1'b0, 3, 1, 2, 32'hBEEFBEEF);
    run_op("lw10",  1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0,         32'hBEEFBEEF, 1'b0, 2, 1, -1, 32'h0);
    run_op("sb_b0", 1'b1, 2'b00, 1'b0, 32'h00000004, 32'hFFFFFF55,  32'h0,        1'b0, 3, 1, 2, 32'h8070F055);
    run_op("e_lh3", 1'b0, 2'b01, 1'b0, 32'h00000003, 32'h0,         32'h0,        1'b1, 1, -1, -1, 32'h0);
    run_op("e_lw6", 1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0,         32'h0,        1'b1, 1, -1, -1, 32'h0);
    run_op("e_sz3", 1'b0, 2'b11, 1'b0, 32'h00000000, 32'h0,         32'h0,        1'b1, 1, -1, -1, 32'h0);
    run_op("e_oor", 1'b0, 2'b10, 1'b0, 32'h00000400, 32'h0,         32'h0,        1'b1, 1, -1, -1, 32'h0);
    run_op("e_sw",  1'b1, 2'b10, 1'b0, 32'h00000400, 32'h12345678,  32'h0,        1'b1, 1, -1, -1, 32'h0);
    run_op("e_sh1", 1'b1, 2'b01, 1'b0, 32'h00000009, 32'h0000AAAA,  32'h0,        1'b1, 1, -1, -1, 32'h0);
    run_op("lw8b",  1'b0, 2'b10, 1'b0, 32'h00000008, 32'h0,         32'h1122EE44, 1'b0, 2, 1, -1, 32'h0);

    // Reset arriving during the write cycle of a byte store.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h00000020;
    bus.req_wdata = 32'h00000011;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rmid_rd", 32'(mem_read), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rmid_wr", 32'(mem_write), 32'd0);
      chk("rmid_resp", 32'(bus.resp_valid), 32'd0);
    end
    rst = 1'b0;
    #1 chk("rmid_ready", 32'(bus.req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rmid_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    chk("rmid_mem", mem[8], 32'hCAFEF00D);
    run_op("lw20",  1'b0, 2'b10, 1'b0, 32'h00000020, 32'h0,         32'hCAFEF00D, 1'b0, 2, 1, -1, 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
